// File: rtl/if_id_skid_reg.sv
// Elastic IF/ID pipeline register: valid/ready handshake with a one-entry skid
// buffer, synchronous flush, hazard stall, RISC-V field decode and bubble counter.
module if_id_skid_reg #(
    parameter int                   PC_W      = 15,
    parameter int                   INSTR_W   = 32,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = 32'h00000013,
    parameter int                   CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               flush,
    input  logic               stall,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    pc_in,
    input  logic [INSTR_W-1:0] instr_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    pc_out,
    output logic [INSTR_W-1:0] instr_out,
    output logic [4:0]         rs1,
    output logic [4:0]         rs2,
    output logic [4:0]         rd,
    output logic [6:0]         opcode,
    output logic [2:0]         funct3,
    output logic [CNT_W-1:0]   bubble_cnt
);

    logic               m_valid_r, m_valid_s;
    logic [PC_W-1:0]    m_pc_r, m_pc_s;
    logic [INSTR_W-1:0] m_instr_r, m_instr_s;
    logic               s_valid_r, s_valid_s;
    logic [PC_W-1:0]    s_pc_r, s_pc_s;
    logic [INSTR_W-1:0] s_instr_r, s_instr_s;
    logic [CNT_W-1:0]   bubble_cnt_r, bubble_cnt_s;
    logic               take_s;
    logic               acc_s;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    assign take_s   = out_ready & ~stall;
    assign in_ready = ~s_valid_r;
    assign acc_s    = in_valid & ~s_valid_r;

    // Next-state for main/skid entries and the bubble counter.
    always_comb begin
        m_valid_s    = m_valid_r;
        m_pc_s       = m_pc_r;
        m_instr_s    = m_instr_r;
        s_valid_s    = s_valid_r;
        s_pc_s       = s_pc_r;
        s_instr_s    = s_instr_r;
        bubble_cnt_s = bubble_cnt_r;

        if (!m_valid_r) begin
            bubble_cnt_s = sat_inc(bubble_cnt_r);
        end else begin
            bubble_cnt_s = bubble_cnt_r;
        end

        if (flush) begin
            m_valid_s = 1'b0;
            s_valid_s = 1'b0;
        end else if (!m_valid_r || take_s) begin
            if (s_valid_r) begin
                // Skid drains first to keep FIFO order; in_ready is low here.
                m_valid_s = 1'b1;
                m_pc_s    = s_pc_r;
                m_instr_s = s_instr_r;
                s_valid_s = 1'b0;
            end else if (acc_s) begin
                m_valid_s = 1'b1;
                m_pc_s    = pc_in;
                m_instr_s = instr_in;
            end else begin
                m_valid_s = 1'b0;
            end
        end else begin
            if (acc_s) begin
                s_valid_s = 1'b1;
                s_pc_s    = pc_in;
                s_instr_s = instr_in;
            end else begin
                s_valid_s = s_valid_r;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid_r    <= 1'b0;
            m_pc_r       <= '0;
            m_instr_r    <= '0;
            s_valid_r    <= 1'b0;
            s_pc_r       <= '0;
            s_instr_r    <= '0;
            bubble_cnt_r <= '0;
        end else begin
            m_valid_r    <= m_valid_s;
            m_pc_r       <= m_pc_s;
            m_instr_r    <= m_instr_s;
            s_valid_r    <= s_valid_s;
            s_pc_r       <= s_pc_s;
            s_instr_r    <= s_instr_s;
            bubble_cnt_r <= bubble_cnt_s;
        end
    end

    assign out_valid  = m_valid_r;
    assign pc_out     = m_valid_r ? m_pc_r : '0;
    assign instr_out  = m_valid_r ? m_instr_r : NOP_INSTR;
    assign rs1        = instr_out[19:15];
    assign rs2        = instr_out[24:20];
    assign rd         = instr_out[11:7];
    assign opcode     = instr_out[6:0];
    assign funct3     = instr_out[14:12];
    assign bubble_cnt = bubble_cnt_r;

endmodule
